// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID elastic stage register.
package ifid_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_skid_reg_pipe_slot.sv
// One storage slot: valid bit plus data, with load, drop and synchronous clear.
module pipe_slot #(
  parameter int unsigned W          = 64,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // drop clears only the valid bit so the data stays visible on the outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= 1'b0;
      if (CLEAR_DATA) q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID two-entry elastic stage register; in_ready does not depend on out_ready.
module ifid_skid_reg
  import ifid_pkg::*;
#(
  parameter int unsigned PC_W           = 32,
  parameter int unsigned INSTR_W        = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  localparam int unsigned DW = PC_W + INSTR_W;

  logic          main_valid, skid_valid;
  logic [DW-1:0] main_data, skid_data, main_next;
  logic          in_fire, out_fire, clr;
  logic          main_load, main_drop, skid_load, skid_drop;

  assign in_ready  = ~skid_valid & ~freeze & ~rst;
  assign out_valid = main_valid & ~freeze;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign clr       = rst | flush;

  // freeze already gates both fires, so it needs no separate hold term here
  always_comb begin
    main_load = (out_fire & skid_valid) | (in_fire & (~main_valid | out_fire));
    main_drop = out_fire & ~main_load;
    skid_load = in_fire & main_valid & ~out_fire;
    skid_drop = out_fire & skid_valid;
    main_next = skid_valid ? skid_data : {in_pc, in_instr};
  end

  pipe_slot #(.W(DW), .CLEAR_DATA(CLEAR_ON_FLUSH)) u_main (
    .clk   (clk),
    .clr   (clr),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_next),
    .valid (main_valid),
    .q     (main_data)
  );

  pipe_slot #(.W(DW), .CLEAR_DATA(CLEAR_ON_FLUSH)) u_skid (
    .clk   (clk),
    .clr   (clr),
    .load  (skid_load),
    .drop  (skid_drop),
    .d     ({in_pc, in_instr}),
    .valid (skid_valid),
    .q     (skid_data)
  );

  assign out_pc    = main_data[DW-1:INSTR_W];
  assign out_instr = main_data[INSTR_W-1:0];

  // skid is only ever occupied behind a valid main entry
  always_comb begin
    if (skid_valid)      occupancy = OCC_TWO;
    else if (main_valid) occupancy = OCC_ONE;
    else                 occupancy = OCC_EMPTY;
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed scenarios plus a randomized queue-model run.
module tb_ifid_skid_reg;
  import ifid_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [1:0]  occupancy;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_pc, b_out_instr;
  logic [1:0]  b_occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifid_skid_reg #(.PC_W(32), .INSTR_W(32), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .occupancy(occupancy)
  );

  ifid_skid_reg #(.PC_W(32), .INSTR_W(32), .CLEAR_ON_FLUSH(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_instr(b_out_instr), .occupancy(b_occupancy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1; in_pc = pc; in_instr = instr;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b pc=%h instr=%h occ=%0d exp v=0 pc=0 instr=0 occ=0",
               out_valid, out_pc, out_instr, occupancy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{32'h0, 32'h4, 32'h8};
    ins = '{32'hA0, 32'hA1, 32'hA2};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(pcs[i], ins[i]);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i] || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h occ=%0d exp v=1 pc=%h instr=%h occ=1",
                 i, out_valid, out_pc, out_instr, occupancy, pcs[i], ins[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
    end
  endtask

  task automatic test_skid_fill();
    out_ready = 1'b0;
    offer(32'h10, 32'hB0);
    step();
    offer(32'h14, 32'hB1);
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h10) begin
      errors++;
      $display("FAIL skid_full got occ=%0d rdy=%b pc=%h exp occ=2 rdy=0 pc=10",
               occupancy, in_ready, out_pc);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'hB0) begin
      errors++; $display("FAIL skid_drain0 got v=%b pc=%h exp v=1 pc=10", out_valid, out_pc);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_instr !== 32'hB1 ||
        occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain1 got v=%b pc=%h occ=%0d rdy=%b exp v=1 pc=14 occ=1 rdy=1",
               out_valid, out_pc, occupancy, in_ready);
    end
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++; $display("FAIL skid_empty got occ=%0d exp=0", occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'h18, 32'hC0);
    step();
    offer(32'h1C, 32'hC1);
    step();
    offer(32'h20, 32'hC2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL flush_two got occ=%0d v=%b pc=%h instr=%h exp occ=0 v=0 pc=0 instr=0",
               occupancy, out_valid, out_pc, out_instr);
    end
    // flush from ONE while the offered entry is actually accepted
    offer(32'h18, 32'hC0);
    step();
    offer(32'h20, 32'hC2);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_one_ready got=%b exp=1", in_ready);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_pc === 32'h20 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL flush_discard_%0d got v=%b pc=%h occ=%0d exp v=0 pc!=20 occ=0",
                 i, out_valid, out_pc, occupancy);
      end
      step();
    end
  endtask

  task automatic test_freeze();
    out_ready = 1'b0;
    offer(32'h30, 32'hD0);
    step();
    freeze = 1'b1;
    out_ready = 1'b1;
    offer(32'h34, 32'hD1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_pc !== 32'h30 || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL freeze_%0d got v=%b rdy=%b pc=%h occ=%0d exp v=0 rdy=0 pc=30 occ=1",
                 i, out_valid, in_ready, out_pc, occupancy);
      end
      step();
    end
    freeze = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h30 || out_instr !== 32'hD0) begin
      errors++; $display("FAIL freeze_release got v=%b pc=%h exp v=1 pc=30", out_valid, out_pc);
    end
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++; $display("FAIL freeze_drain got occ=%0d exp=0", occupancy);
    end
  endtask

  task automatic test_no_clear();
    out_ready = 1'b0;
    offer(32'h40, 32'hE0);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (b_out_valid !== 1'b0 || b_out_pc !== 32'h40 || b_out_instr !== 32'hE0 || b_occupancy !== 2'd0) begin
      errors++;
      $display("FAIL keep_flush got v=%b pc=%h instr=%h occ=%0d exp v=0 pc=40 instr=e0 occ=0",
               b_out_valid, b_out_pc, b_out_instr, b_occupancy);
    end
    checks++;
    if (out_pc !== 32'h0) begin
      errors++; $display("FAIL clear_flush got pc=%h exp=0", out_pc);
    end
  endtask

  // Reference: bounded FIFO of depth 2 plus the last entry shown on the outputs.
  task automatic test_random(input int n);
    ifid_entry_t q[$];
    ifid_entry_t shown, e;
    logic exp_rdy, exp_vld, inf, outf;
    shown = '0;
    q.delete();
    rst = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      #1;
      exp_rdy = !rst && !freeze && (q.size() < 2);
      exp_vld = !freeze && (q.size() > 0);
      checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_vld || occupancy !== 2'(q.size()) ||
          out_pc !== shown.pc || out_instr !== shown.instr) begin
        errors++;
        $display("FAIL rand_%0d got rdy=%b v=%b occ=%0d pc=%h instr=%h exp rdy=%b v=%b occ=%0d pc=%h instr=%h",
                 i, in_ready, out_valid, occupancy, out_pc, out_instr,
                 exp_rdy, exp_vld, q.size(), shown.pc, shown.instr);
      end
      inf  = in_valid && exp_rdy;
      outf = out_ready && exp_vld;
      step();
      if (rst || flush) begin
        q.delete();
        shown = '0;
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) begin
          e.pc = in_pc; e.instr = in_instr;
          q.push_back(e);
        end
        if (q.size() > 0) shown = q[0];
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush();
    test_freeze();
    test_no_clear();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
